// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: streams a stored frame from a 1-cycle-latency RAM as valid/data/last beats, PASSES passes per start
// Ports: clk_i_pix_rd/rst_i_pix_rd clock and sync active-high reset; start_i_pix_rd run request (IDLE only);
//   ready_i_pix_rd downstream ready; ram_en_o/ram_addr_o/ram_data_i RAM read port;
//   en_o/data_o/last_o/pass_o output beat; busy_o run in progress; done_o end-of-run pulse.
module pixel_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int PASSES     = 2
) (
  input  logic                  clk_i_pix_rd,
  input  logic                  rst_i_pix_rd,
  input  logic                  start_i_pix_rd,
  input  logic                  ready_i_pix_rd,
  output logic                  ram_en_o_pix_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr_o_pix_rd,
  input  logic [DATA_WIDTH-1:0] ram_data_i_pix_rd,
  output logic                  en_o_pix_rd,
  output logic [DATA_WIDTH-1:0] data_o_pix_rd,
  output logic                  last_o_pix_rd,
  output logic [1:0]            pass_o_pix_rd,
  output logic                  busy_o_pix_rd,
  output logic                  done_o_pix_rd
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);
  localparam int EW = DATA_WIDTH + 3;
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0] rpass_q, rpass_d;
  logic fl_q, fl_last_q;
  logic [1:0] fl_pass_q;
  logic [1:0] cnt_q, cnt_d, wptr;
  logic [EW-1:0] ent_q [2];
  logic [EW-1:0] ent_d [2];
  logic [EW-1:0] ent_new;
  logic [2:0] credit;
  logic issue, pop, wrap;
  // buffer entries are {last, pass, data}; entry 0 is the head presented on the outputs
  assign pop = cnt_q != 2'd0 && ready_i_pix_rd;
  // outstanding = buffered + in flight, less the beat leaving this cycle
  assign credit = {1'b0, cnt_q} + {2'b0, fl_q} - {2'b0, pop};
  assign issue = state_q == RUN && credit < 3'd2;
  assign wrap = addr_q == LAST_ADDR;
  assign wptr = cnt_q - {1'b0, pop};
  assign cnt_d = cnt_q + {1'b0, fl_q} - {1'b0, pop};
  assign ent_new = {fl_last_q, fl_pass_q, ram_data_i_pix_rd};
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rpass_d = rpass_q;
    ent_d[0] = fl_q && wptr == 2'd0 ? ent_new : pop ? ent_q[1] : ent_q[0];
    ent_d[1] = fl_q && wptr == 2'd1 ? ent_new : ent_q[1];
    case (state_q)
      IDLE: begin
        addr_d = '0;
        rpass_d = '0;
        state_d = start_i_pix_rd ? RUN : IDLE;
      end
      RUN: if (issue) begin
        addr_d = wrap ? '0 : addr_q + 1'b1;
        rpass_d = wrap ? rpass_q + 2'd1 : rpass_q;
        state_d = wrap && rpass_q == LAST_PASS ? DRAIN : RUN;
      end
      // leave on the edge that accepts the final beat so done lines up with it
      DRAIN: state_d = cnt_d == 2'd0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i_pix_rd) begin
    if (rst_i_pix_rd) begin
      state_q <= IDLE;
      addr_q <= '0;
      rpass_q <= '0;
      fl_q <= 1'b0;
      fl_last_q <= 1'b0;
      fl_pass_q <= '0;
      cnt_q <= '0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rpass_q <= rpass_d;
      fl_q <= issue;
      fl_last_q <= wrap;
      fl_pass_q <= rpass_q;
      cnt_q <= cnt_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end
  assign ram_en_o_pix_rd = issue;
  assign ram_addr_o_pix_rd = addr_q;
  assign en_o_pix_rd = cnt_q != 2'd0;
  assign {last_o_pix_rd, pass_o_pix_rd, data_o_pix_rd} = ent_q[0];
  assign busy_o_pix_rd = state_q == RUN || state_q == DRAIN;
  assign done_o_pix_rd = state_q == DONE;
endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb_pixel_stream_reader: scoreboard bench for pixel_stream_reader on an 8-pixel, 2-pass frame
module tb_pixel_stream_reader;
  localparam int DW = 8, D = 8, AW = $clog2(D), P = 2;
  logic clk = 0, rst = 1, start = 0, ready = 1;
  logic ram_en, en, last, busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data = '0, data;
  logic [1:0] pass;
  logic [DW-1:0] mem [D];
  logic [10:0] exp_q [$];
  logic [10:0] held;
  int total = 0, bad = 0;
  int phase = 0, issued = 0, xferred = 0, cyc_n = 0, start_cyc = 0, done_cyc = 0, runs = 0, dones = 0;
  bit stall_prev = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en) ram_data <= mem[ram_addr];
  pixel_stream_reader #(.DATA_WIDTH(DW), .RAM_DEPTH(D), .PASSES(P)) dut (
    .clk_i_pix_rd(clk), .rst_i_pix_rd(rst), .start_i_pix_rd(start), .ready_i_pix_rd(ready),
    .ram_en_o_pix_rd(ram_en), .ram_addr_o_pix_rd(ram_addr), .ram_data_i_pix_rd(ram_data),
    .en_o_pix_rd(en), .data_o_pix_rd(data), .last_o_pix_rd(last), .pass_o_pix_rd(pass),
    .busy_o_pix_rd(busy), .done_o_pix_rd(done));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit rdy, input bit st);
    bit xfer;
    logic [10:0] beat;
    int outst;
    ready = rdy;
    start = st;
    @(negedge clk);
    xfer = en && ready;
    beat = {last, pass, data};
    chk("busy", busy, phase == 1);
    chk("done", done, phase == 2);
    if (stall_prev) begin
      chk("stall_en", en, 1);
      chk("stall_hold", beat, held);
    end
    stall_prev = en && !ready;
    held = beat;
    outst = issued - xferred;
    if (ram_en) begin
      chk("credit", outst - int'(xfer) < 2, 1);
      chk("ram_en_in_run", phase, 1);
      chk("addr_range", ram_addr < D, 1);
      issued++;
    end
    if (phase == 1 && cyc_n == start_cyc + 1) begin
      chk("first_ram_en", ram_en, 1);
      chk("first_addr", ram_addr, 0);
    end
    if (xfer) begin
      chk("beat", beat, exp_q.size() != 0 ? {21'd0, exp_q[0]} : 32'hffff_ffff);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      xferred++;
    end
    if (done) dones++;
    if (phase == 0 && st) begin
      phase = 1;
      runs++;
      start_cyc = cyc_n;
      for (int p = 0; p < P; p++)
        for (int i = 0; i < D; i++) exp_q.push_back({i == D - 1, 2'(p), mem[i]});
    end else if (phase == 1 && xfer && exp_q.size() == 0) phase = 2;
    else if (phase == 2) begin
      phase = 0;
      done_cyc = cyc_n;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic do_reset();
    rst = 1;
    start = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_outputs", {ram_en, ram_addr, en, data, last, pass, busy, done}, 0);
    phase = 0;
    exp_q.delete();
    issued = 0;
    xferred = 0;
    stall_prev = 0;
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  task automatic run_until_idle(input int mode);
    int k;
    for (int n = 0; n < 400 && phase != 0; n++) begin
      k = cyc_n - start_cyc;
      cycle(mode == 0 ? 1'b1 : mode == 1 ? k[0] : mode == 2 ? !(k >= 6 && k < 11) : $urandom_range(0, 3) != 0, 1'b0);
    end
    chk("run_finished", phase, 0);
  endtask
  initial begin
    int r0, base;
    for (int i = 0; i < D; i++) mem[i] = DW'(10 + i);
    do_reset();
    cycle(1, 1);
    run_until_idle(0);
    chk("done_latency", done_cyc - start_cyc, 19);
    cycle(1, 0);
    chk("idle_busy", busy, 0);
    cycle(1, 1);
    run_until_idle(1);
    cycle(1, 1);
    run_until_idle(2);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < D; i++) mem[i] = DW'($urandom);
      cycle(1, 1);
      run_until_idle(3);
    end
    r0 = runs;
    for (int n = 0; n < 40; n++) cycle(1, 1);
    run_until_idle(0);
    chk("held_start_runs", runs - r0 >= 2, 1);
    chk("done_per_run", dones, runs);
    for (int i = 0; i < D; i++) mem[i] = DW'($urandom);
    cycle(1, 1);
    base = xferred;
    for (int n = 0; n < 100 && xferred - base < D + 5; n++) cycle(1, 0);
    chk("reached_pass1_beat5", xferred - base, D + 5);
    do_reset();
    cycle(1, 1);
    run_until_idle(0);
    chk("after_reset_latency", done_cyc - start_cyc, 19);
    chk("done_per_run_final", dones, runs - 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_stream_reader.md
# pixel_stream_reader

Frame-buffer read engine that streams a stored grayscale frame, pixel by pixel, into a downstream consumer. It is the driver side of the pixel stream interface: valid, data, last. It feeds the min/max finder on pass 0 and the contrast-stretch datapath on pass 1. It reads a synchronous single-port RAM with 1-cycle read latency and issues PASSES back-to-back full-frame passes per start. It supports downstream backpressure through a 2-entry output buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- RAM_DEPTH, 76800, pixels per frame (320x240)
- ADDR_WIDTH, $clog2(RAM_DEPTH), RAM address width
- PASSES, 2, frame passes per start (1..4)

Ports:
- clk_i_pix_rd  in  1  single clock, all logic on rising edge
- rst_i_pix_rd  in  1  reset, synchronous, active-high
- start_i_pix_rd  in  1  start request, sampled only in IDLE
- ready_i_pix_rd  in  1  downstream ready; tie to 1 for consumers without backpressure
- ram_en_o_pix_rd  out  1  RAM read enable
- ram_addr_o_pix_rd  out  ADDR_WIDTH  RAM read address
- ram_data_i_pix_rd  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en_o
- en_o_pix_rd  out  1  output beat valid
- data_o_pix_rd  out  DATA_WIDTH  pixel value
- last_o_pix_rd  out  1  final pixel of the current pass, qualified by en_o
- pass_o_pix_rd  out  2  pass index of the beat on data_o
- busy_o_pix_rd  out  1  high from the cycle after start is accepted until done
- done_o_pix_rd  out  1  1-cycle pulse after the final beat of the final pass

## Operation
- A beat transfers on a clock edge where en_o && ready_i.
- While en_o && !ready_i, data_o, last_o and pass_o hold stable.
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE: if start_i is high, go to RUN. Clear the read address and read pass counters. Set busy.
  - RUN: issue reads under the credit rule. Each issued read increments the address. When the address hits RAM_DEPTH-1, wrap to 0 and increment the read pass. After the read of address RAM_DEPTH-1 in pass PASSES-1, go to DRAIN.
  - DRAIN: issue no reads. Once the buffer is empty and no read is in flight, go to DONE.
  - DONE: assert done_o for one cycle, clear busy, go to IDLE.
- Credit rule: issue a read when (buffer occupancy + in-flight reads − transfer this cycle) < 2. The 2-entry buffer therefore never overflows. With ready held high, throughput is 1 beat/cycle with no bubbles.
- Each buffer entry carries data, last and pass. Tags are computed at read issue:
  - last = (addr == RAM_DEPTH-1)
  - pass = the read pass counter
- Consecutive passes are contiguous. Pass p+1 address 0 immediately follows pass p address RAM_DEPTH-1, with no gap.
- start_i is ignored while busy. start_i held high in DONE does not restart until the cycle after return to IDLE.
- Reset: all state returns to IDLE, counters and buffer clear, and any in-flight RAM read is discarded. Reset overrides everything, mid-pass included.

## Timing
- Reset values: ram_en_o=0, ram_addr_o=0, en_o=0, data_o=0, last_o=0, pass_o=0, busy_o=0, done_o=0.
- If start is sampled at edge k:
  - busy and ram_en_o are high after k, with ram_addr_o=0.
  - The first beat is valid (en_o=1, data=RAM[0]) after edge k+2.
- With ready=1 throughout, beat i of pass p is valid after edge k+2+p·RAM_DEPTH+i.
- done_o is high for exactly one cycle, after the edge that accepts the final beat (last_o=1, pass_o=PASSES-1). busy_o falls on the same edge that done_o rises.
- ram_en_o never asserts outside RUN.
- The address register wraps only at RAM_DEPTH-1, never at 2^ADDR_WIDTH.

## Test plan
- RAM_DEPTH=8, PASSES=2, RAM[i]=10+i, ready=1, start pulse:
  - beats 10..17 with pass_o=0, then 10..17 with pass_o=1, 16 consecutive cycles
  - last_o on beats 7 and 15
  - done 1 cycle after beat 15, busy low after
- Same configuration with ready toggling every cycle, and separately ready low for 5 cycles mid-pass:
  - identical beat sequence with no loss or duplication
  - data held stable while stalled
  - ram_en_o never asserts with occupancy+inflight=2
- start_i held high for 40 cycles:
  - exactly one run while busy
  - a second run begins only after return to IDLE
  - done pulses once per run
- rst_i asserted at beat 5 of pass 1, then released:
  - all outputs 0 the cycle after reset
  - a new start yields a clean full run from RAM[0], pass 0
- Full-size frame (76800 pixels, PASSES=1) from min_max_datas.mem, driving min_max_find with ready tied 1:
  - min_max_find reports min=28, max=223
  - exactly 76800 beats with a single last
